// File: rtl/simon_engine.sv
// Simon sequencer: LFSR-built sequence, timed tone/gap replay, press checking with input timeout.
// Outputs come straight from flops (or from mem indexed by a flopped idx); press pulses never backpressure.
module simon_engine #(
  parameter int          NUM_BTNS       = 4,
  parameter int          MAX_LEN        = 16,
  parameter int          TONE_CYCLES    = 25_000_000,
  parameter int          GAP_CYCLES     = 12_500_000,
  parameter int          TIMEOUT_CYCLES = 250_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         W              = $clog2(NUM_BTNS),
  localparam int         LW             = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          btn_valid,
  input  logic [W-1:0]  btn_num,
  output logic          simon_turn,
  output logic          play_valid,
  output logic [W-1:0]  play_num,
  output logic [LW-1:0] level,
  output logic          game_over,
  output logic          win
);

  localparam int IW   = $clog2(MAX_LEN);
  localparam int MAXA = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int MAXC = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_GAP, WAIT_IN, LOSE, WIN} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [W-1:0]  mem [MAX_LEN];
  logic [LW-1:0] len;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          last_step;

  assign last_step = (LW'(idx) == len - LW'(1));
  assign level     = len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      len        <= '0;
      idx        <= '0;
      cnt        <= '0;
      simon_turn <= 1'b0;
      play_valid <= 1'b0;
      play_num   <= '0;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      // Fibonacci taps 16,14,13,11 in right-shift form
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      case (state)
        IDLE, LOSE, WIN: begin
          if (start) begin
            state      <= ADD;
            len        <= '0;
            simon_turn <= 1'b1;
            game_over  <= 1'b0;
            win        <= 1'b0;
          end
        end
        ADD: begin
          mem[len[IW-1:0]] <= lfsr[W-1:0];
          len              <= len + LW'(1);
          idx              <= '0;
          cnt              <= '0;
          state            <= SHOW_ON;
          play_valid       <= 1'b1;
          // on the first round mem[0] is being written this very edge
          play_num         <= (len == '0) ? lfsr[W-1:0] : mem[0];
        end
        SHOW_ON: begin
          if (cnt == CW'(TONE_CYCLES - 1)) begin
            cnt        <= '0;
            state      <= SHOW_GAP;
            play_valid <= 1'b0;
            play_num   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW_GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (last_step) begin
              idx        <= '0;
              state      <= WAIT_IN;
              simon_turn <= 1'b0;
            end else begin
              idx        <= idx + IW'(1);
              state      <= SHOW_ON;
              play_valid <= 1'b1;
              play_num   <= mem[idx + IW'(1)];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IN: begin
          // a press on the expiry cycle takes priority over the timeout
          if (btn_valid) begin
            cnt <= '0;
            if (btn_num != mem[idx]) begin
              state     <= LOSE;
              game_over <= 1'b1;
            end else if (last_step) begin
              if (len == LW'(MAX_LEN)) begin
                state <= WIN;
                win   <= 1'b1;
              end else begin
                state      <= ADD;
                simon_turn <= 1'b1;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state     <= LOSE;
            game_over <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_engine.sv
// Directed bench for simon_engine: a 4-button/4-step instance and an 8-button/2-step instance.
module tb_simon_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_btn_valid = 1'b0;
  logic [1:0] a_btn_num = '0;
  logic       a_simon_turn, a_play_valid, a_game_over, a_win;
  logic [1:0] a_play_num;
  logic [2:0] a_level;

  logic       b_start = 1'b0, b_btn_valid = 1'b0;
  logic [2:0] b_btn_num = '0;
  logic       b_simon_turn, b_play_valid, b_game_over, b_win;
  logic [2:0] b_play_num;
  logic [1:0] b_level;

  simon_engine #(.NUM_BTNS(4), .MAX_LEN(4), .TONE_CYCLES(4), .GAP_CYCLES(2),
                 .TIMEOUT_CYCLES(10), .LFSR_SEED(16'hACE1)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .btn_valid(a_btn_valid), .btn_num(a_btn_num),
    .simon_turn(a_simon_turn), .play_valid(a_play_valid), .play_num(a_play_num),
    .level(a_level), .game_over(a_game_over), .win(a_win));

  simon_engine #(.NUM_BTNS(8), .MAX_LEN(2), .TONE_CYCLES(4), .GAP_CYCLES(2),
                 .TIMEOUT_CYCLES(10), .LFSR_SEED(16'hACE1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .btn_valid(b_btn_valid), .btn_num(b_btn_num),
    .simon_turn(b_simon_turn), .play_valid(b_play_valid), .play_num(b_play_num),
    .level(b_level), .game_over(b_game_over), .win(b_win));

  bit sel = 1'b0;
  logic       o_turn, o_pv, o_go, o_win;
  logic [2:0] o_pn, o_level;
  assign o_turn  = sel ? b_simon_turn : a_simon_turn;
  assign o_pv    = sel ? b_play_valid : a_play_valid;
  assign o_go    = sel ? b_game_over  : a_game_over;
  assign o_win   = sel ? b_win        : a_win;
  assign o_pn    = sel ? b_play_num   : {1'b0, a_play_num};
  assign o_level = sel ? {1'b0, b_level} : a_level;

  int n_err = 0;
  int n_chk = 0;
  int exp_mem[4];
  int obs_seq[4];

  // Reference LFSR: free-running from reset, same polynomial as the game generator
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[5] ^ m_lfsr[3] ^ m_lfsr[2] ^ m_lfsr[0], m_lfsr[15:1]};
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int maxlen();
    return sel ? 2 : 4;
  endfunction

  task automatic drive_btn(input bit v, input int n);
    if (sel) begin b_btn_valid = v; b_btn_num = n[2:0]; end
    else     begin a_btn_valid = v; a_btn_num = n[1:0]; end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_turn"},  o_turn,  0);
    check({tag, "_pv"},    o_pv,    0);
    check({tag, "_pn"},    o_pn,    0);
    check({tag, "_level"}, o_level, 0);
    check({tag, "_go"},    o_go,    0);
    check({tag, "_win"},   o_win,   0);
  endtask

  // Called in the ADD cycle: the step stored at the next edge is the current LFSR value
  task automatic capture(input int i);
    exp_mem[i] = int'(m_lfsr) & (sel ? 7 : 3);
  endtask

  task automatic do_start();
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    tick();
    b_start = 1'b0;
    a_start = 1'b0;
    check("add_turn", o_turn, 1);
    check("add_level", o_level, 0);
    check("add_go", o_go, 0);
    check("add_win", o_win, 0);
    capture(0);
  endtask

  // Entered in the ADD cycle; returns in the first WAIT_IN cycle
  task automatic replay(input int len, input bit noise);
    tick();
    for (int i = 0; i < len; i++) begin
      int on_n;
      int gap_n;
      on_n = 0;
      gap_n = 0;
      check("play_num", o_pn, exp_mem[i]);
      check("level", o_level, len);
      obs_seq[i] = o_pn;
      while (o_pv && on_n < 50) begin
        if (noise) drive_btn(1'b1, exp_mem[i] ^ 1);
        tick();
        on_n++;
      end
      drive_btn(1'b0, 0);
      check("tone_len", on_n, 4);
      check("gap_num", o_pn, 0);
      while (!o_pv && o_turn && gap_n < 50) begin
        tick();
        gap_n++;
      end
      check("gap_len", gap_n, 2);
    end
    check("turn_off", o_turn, 0);
    check("wait_go", o_go, 0);
  endtask

  task automatic press(input int n);
    drive_btn(1'b1, n);
    tick();
    drive_btn(1'b0, 0);
  endtask

  // Echo the replayed sequence back-to-back
  task automatic answer(input int r);
    for (int i = 0; i < r; i++) press(obs_seq[i]);
    if (r < maxlen()) begin
      check("next_add", o_turn, 1);
      check("next_go", o_go, 0);
      capture(r);
    end else begin
      check("win", o_win, 1);
      check("win_go", o_go, 0);
      check("win_level", o_level, r);
      check("win_turn", o_turn, 0);
    end
  endtask

  task automatic wait_lose(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!o_go && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check_zero("rst");
    reset = 1'b0;
    repeat (3) tick();
    check_zero("idle");

    // Full game to a win
    sel = 1'b0;
    do_start();
    for (int r = 1; r <= 4; r++) begin
      replay(r, 1'b0);
      answer(r);
    end
    press(0);
    check("win_hold", o_win, 1);
    check("win_hold_level", o_level, 4);

    // Wrong second press in round 2
    do_start();
    replay(1, 1'b0);
    answer(1);
    replay(2, 1'b0);
    press(obs_seq[0]);
    press((obs_seq[1] + 1) % 4);
    check("lose", o_go, 1);
    check("lose_level", o_level, 2);
    press(obs_seq[1]);
    press(obs_seq[0]);
    check("lose_hold", o_go, 1);
    check("lose_hold_level", o_level, 2);
    check("lose_no_win", o_win, 0);

    // Timeout with no press, then a press on the expiry cycle
    do_start();
    replay(1, 1'b0);
    wait_lose("timeout_len", 10);
    check("timeout_level", o_level, 1);
    do_start();
    replay(1, 1'b0);
    answer(1);
    replay(2, 1'b0);
    repeat (9) tick();
    press(obs_seq[0]);
    check("expiry_press", o_go, 0);
    wait_lose("timeout_restart", 10);

    // Reset during the third round's replay
    do_start();
    replay(1, 1'b0);
    answer(1);
    replay(2, 1'b0);
    answer(2);
    tick();
    check("r3_on", o_pv, 1);
    check("r3_level", o_level, 3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("mid_rst");
    do_start();
    replay(1, 1'b0);

    // Eight buttons, two steps, presses during replay ignored
    sel = 1'b1;
    do_start();
    replay(1, 1'b1);
    answer(1);
    replay(2, 1'b1);
    answer(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
